// File: rtl/calc_req_scheduler_if.sv
// rtl/calc_req_scheduler_if.sv - port request/response and ALU issue/return bundle for calc_req_scheduler
interface calc_req_scheduler_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
    logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
    logic [1:0]        out_resp1, out_resp2, out_resp3, out_resp4;
    logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;
    logic              alu_valid_out;
    logic [3:0]        alu_cmd_out;
    logic [DATA_W-1:0] alu_op1_out, alu_op2_out;
    logic              alu_ready_in;
    logic              alu_valid_in;
    logic [DATA_W-1:0] alu_result_in;
    logic [1:0]        alu_resp_in;
    logic              sched_err_out;

    modport master (
        output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        output alu_ready_in, alu_valid_in, alu_result_in, alu_resp_in,
        input  out_resp1, out_resp2, out_resp3, out_resp4,
        input  out_data1, out_data2, out_data3, out_data4,
        input  alu_valid_out, alu_cmd_out, alu_op1_out, alu_op2_out, sched_err_out
    );

    modport slave (
        input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
        input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
        input  alu_ready_in, alu_valid_in, alu_result_in, alu_resp_in,
        output out_resp1, out_resp2, out_resp3, out_resp4,
        output out_data1, out_data2, out_data3, out_data4,
        output alu_valid_out, alu_cmd_out, alu_op1_out, alu_op2_out, sched_err_out
    );
endinterface

// File: rtl/calc_req_scheduler.sv
// rtl/calc_req_scheduler.sv - four-port request scheduler for the shared calc ALU (CALC_SCHED_FIXED_PRIO_EN selects fixed priority)
module calc_req_scheduler #(
    parameter int DATA_W = 32,
    parameter int NPORT  = 4
) (
    input  logic                c_clk,
    input  logic                reset,
    calc_req_scheduler_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_OP2, S_PEND, S_FLIGHT, S_RESP} state_t;

    logic [3:0]        req_cmd  [NPORT];
    logic [DATA_W-1:0] req_data [NPORT];
    state_t            state_q  [NPORT];
    state_t            state_d  [NPORT];
    logic [3:0]        cmd_q    [NPORT];
    logic [DATA_W-1:0] op1_q    [NPORT];
    logic [DATA_W-1:0] op2_q    [NPORT];
    logic [DATA_W-1:0] data_q   [NPORT];
    logic [1:0]        resp_q   [NPORT];
    logic [1:0]        fifo_q   [4];
    logic [1:0]        wr_ptr_q, rd_ptr_q;
    logic [2:0]        count_q;
    logic [NPORT-1:0]  eligible;
    logic              grant_vld;
    logic [1:0]        grant_idx, search_base, head_tag;
    logic              ret_hit, ret_orphan;

    assign req_cmd[0]  = bus.req1_cmd_in;
    assign req_cmd[1]  = bus.req2_cmd_in;
    assign req_cmd[2]  = bus.req3_cmd_in;
    assign req_cmd[3]  = bus.req4_cmd_in;
    assign req_data[0] = bus.req1_data_in;
    assign req_data[1] = bus.req2_data_in;
    assign req_data[2] = bus.req3_data_in;
    assign req_data[3] = bus.req4_data_in;
    assign bus.out_resp1 = resp_q[0];
    assign bus.out_resp2 = resp_q[1];
    assign bus.out_resp3 = resp_q[2];
    assign bus.out_resp4 = resp_q[3];
    assign bus.out_data1 = data_q[0];
    assign bus.out_data2 = data_q[1];
    assign bus.out_data3 = data_q[2];
    assign bus.out_data4 = data_q[3];

    function automatic logic cmd_ok(input logic [3:0] c);
        return (c == 4'd1) || (c == 4'd2) || (c == 4'd5) || (c == 4'd6);
    endfunction

    assign head_tag   = fifo_q[rd_ptr_q];
    assign ret_hit    = bus.alu_valid_in && (count_q != 3'd0);
    assign ret_orphan = bus.alu_valid_in && (count_q == 3'd0);

    // A port in OP2 already competes: operand 2 is forwarded from the input so issue lands at T+2.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NPORT; i++) begin
            eligible[i] = (state_q[i] == S_PEND) ||
                          ((state_q[i] == S_OP2) && cmd_ok(cmd_q[i]));
        end
    end

`ifdef CALC_SCHED_FIXED_PRIO_EN
    assign search_base = 2'd0;
`else
    logic [1:0] rr_ptr_q;
    assign search_base = rr_ptr_q;

    always_ff @(posedge c_clk) begin
        if (reset) begin
            rr_ptr_q <= 2'd0;
        end else if (grant_vld) begin
            rr_ptr_q <= grant_idx + 2'd1;
        end
    end
`endif

    // Scan from the far end so the closest eligible port to search_base wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = 2'd0;
        for (int k = NPORT - 1; k >= 0; k--) begin
            if (bus.alu_ready_in && eligible[search_base + 2'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = search_base + 2'(k);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPORT; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                S_IDLE:   if (req_cmd[i] != 4'd0) state_d[i] = S_OP2;
                S_OP2: begin
                    if (!cmd_ok(cmd_q[i]))                          state_d[i] = S_RESP;
                    else if (grant_vld && (grant_idx == 2'(i)))     state_d[i] = S_FLIGHT;
                    else                                            state_d[i] = S_PEND;
                end
                S_PEND:   if (grant_vld && (grant_idx == 2'(i))) state_d[i] = S_FLIGHT;
                S_FLIGHT: if (ret_hit && (head_tag == 2'(i)))    state_d[i] = S_RESP;
                S_RESP:   state_d[i] = (req_cmd[i] != 4'd0) ? S_OP2 : S_IDLE;
                default:  state_d[i] = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            for (int i = 0; i < NPORT; i++) begin
                state_q[i] <= S_IDLE;
                cmd_q[i]   <= 4'd0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= 2'b00;
                data_q[i]  <= '0;
            end
            for (int f = 0; f < 4; f++) fifo_q[f] <= 2'd0;
            wr_ptr_q          <= 2'd0;
            rd_ptr_q          <= 2'd0;
            count_q           <= 3'd0;
            bus.alu_valid_out <= 1'b0;
            bus.alu_cmd_out   <= 4'd0;
            bus.alu_op1_out   <= '0;
            bus.alu_op2_out   <= '0;
            bus.sched_err_out <= 1'b0;
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                state_q[i] <= state_d[i];
                if (((state_q[i] == S_IDLE) || (state_q[i] == S_RESP)) && (req_cmd[i] != 4'd0)) begin
                    cmd_q[i] <= req_cmd[i];
                    op1_q[i] <= req_data[i];
                end
                if (state_q[i] == S_OP2) op2_q[i] <= req_data[i];
                resp_q[i] <= 2'b00;
                data_q[i] <= '0;
                if (state_d[i] == S_RESP) begin
                    if (state_q[i] == S_OP2) begin
                        resp_q[i] <= 2'b10;
                    end else begin
                        resp_q[i] <= bus.alu_resp_in;
                        data_q[i] <= bus.alu_result_in;
                    end
                end
            end

            bus.alu_valid_out <= grant_vld;
            if (grant_vld) begin
                bus.alu_cmd_out  <= cmd_q[grant_idx];
                bus.alu_op1_out  <= op1_q[grant_idx];
                bus.alu_op2_out  <= (state_q[grant_idx] == S_OP2) ? req_data[grant_idx] : op2_q[grant_idx];
                fifo_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (ret_hit) rd_ptr_q <= rd_ptr_q + 2'd1;
            count_q           <= count_q + {2'b00, grant_vld} - {2'b00, ret_hit};
            bus.sched_err_out <= ret_orphan;
        end
    end
endmodule
